// File: rtl/stereo_pkg.sv
// Shared types and constants for the stereo grayscale front end:
// pixel formats, luminance weights and the feeder state encoding.
package stereo_pkg;

  localparam int ROW_WIDTH_DEF = 800;
  localparam int ADDR_W_DEF    = 10;

  localparam logic [7:0] W_R = 8'd77;
  localparam logic [7:0] W_G = 8'd150;
  localparam logic [7:0] W_B = 8'd29;

  typedef enum logic {
    S_FILL = 1'b0,
    S_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb10_t;

  typedef logic [8:0] gray9_t;

  // Weights sum to 256, so the 18-bit sum cannot overflow; >>9 is Y10[9:1].
  function automatic gray9_t rgb_to_y9(input rgb10_t p);
    logic [17:0] sum;
    sum = 18'(W_R) * 18'(p.r) + 18'(W_G) * 18'(p.g) + 18'(W_B) * 18'(p.b);
    return 9'(sum >> 9);
  endfunction

endpackage

// File: rtl/stereo_gray_feeder_if.sv
// Pixel-in / pulse-out bundle between the camera streams, the feeder
// and the disparity stage.
interface stereo_gray_feeder_if;
  import stereo_pkg::*;

  // Inputs: i_valid_* marks one pixel per high cycle with no back-pressure;
  // i_ready is a level from the consumer allowing the next o_valid pulse.
  // Outputs: o_valid_* are single-cycle pulses, never high on consecutive cycles.
  logic       i_valid_l;
  logic [9:0] i_R_l, i_G_l, i_B_l;
  logic       i_valid_r;
  logic [9:0] i_R_r, i_G_r, i_B_r;
  logic       i_ready;
  logic       o_valid_l, o_valid_r;
  gray9_t     o_data_l, o_data_r;
  logic       o_row_done;
  logic       o_overflow;

  modport master (
    output i_valid_l, i_R_l, i_G_l, i_B_l,
    output i_valid_r, i_R_r, i_G_r, i_B_r,
    output i_ready,
    input  o_valid_l, o_valid_r, o_data_l, o_data_r, o_row_done, o_overflow
  );

  modport slave (
    input  i_valid_l, i_R_l, i_G_l, i_B_l,
    input  i_valid_r, i_R_r, i_G_r, i_B_r,
    input  i_ready,
    output o_valid_l, o_valid_r, o_data_l, o_data_r, o_row_done, o_overflow
  );

endinterface

// File: rtl/stereo_gray_feeder_rgb_to_gray.sv
// One-stage registered RGB -> 9-bit luminance converter; the valid flag
// travels alongside the result.
module rgb_to_gray
  import stereo_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_valid,
  input  rgb10_t i_rgb,
  output logic   o_valid,
  output gray9_t o_gray
);

  logic   valid_d, valid_q;
  gray9_t gray_d, gray_q;

  always_comb begin
    valid_d = i_valid;
    gray_d  = i_valid ? rgb_to_y9(i_rgb) : gray_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      gray_q  <= '0;
    end else begin
      valid_q <= valid_d;
      gray_q  <= gray_d;
    end
  end

  assign o_valid = valid_q;
  assign o_gray  = gray_q;

endmodule

// File: rtl/stereo_gray_feeder.sv
// Buffers one luminance row per camera and replays both rows in lock-step
// as spaced single-cycle pulses to the disparity stage.
module stereo_gray_feeder
  import stereo_pkg::*;
#(
  parameter int ROW_WIDTH = ROW_WIDTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  stereo_gray_feeder_if.slave bus,
  output state_e              o_dbg_state
);

  localparam int MEM_AW = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
  localparam logic [ADDR_W-1:0] FULL = ADDR_W'(ROW_WIDTH);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] wcnt_l_d, wcnt_l_q, wcnt_r_d, wcnt_r_q;
  logic [ADDR_W-1:0] rcnt_d, rcnt_q;
  logic              phase_d, phase_q;
  logic              valid_d, valid_q;
  logic              row_done_d, row_done_q;
  logic              overflow_d, overflow_q;
  gray9_t            data_l_d, data_l_q, data_r_d, data_r_q;

  rgb10_t pix_l, pix_r;
  logic   cv_valid_l, cv_valid_r;
  gray9_t cv_gray_l, cv_gray_r;
  logic   in_fill;
  logic   we_l, we_r, drop_l, drop_r;

  gray9_t mem_l [ROW_WIDTH];
  gray9_t mem_r [ROW_WIDTH];

  assign pix_l   = {bus.i_R_l, bus.i_G_l, bus.i_B_l};
  assign pix_r   = {bus.i_R_r, bus.i_G_r, bus.i_B_r};
  assign in_fill = (state_q == S_FILL);

  // Inputs arriving during replay never enter the converters.
  rgb_to_gray u_cvt_l (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.i_valid_l & in_fill),
    .i_rgb   (pix_l),
    .o_valid (cv_valid_l),
    .o_gray  (cv_gray_l)
  );

  rgb_to_gray u_cvt_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.i_valid_r & in_fill),
    .i_rgb   (pix_r),
    .o_valid (cv_valid_r),
    .o_gray  (cv_gray_r)
  );

  // A converted pixel is dropped if its row is already full or replay has begun.
  assign we_l   = cv_valid_l && in_fill && (wcnt_l_q != FULL);
  assign we_r   = cv_valid_r && in_fill && (wcnt_r_q != FULL);
  assign drop_l = cv_valid_l && !we_l;
  assign drop_r = cv_valid_r && !we_r;

  always_ff @(posedge clk) begin
    if (we_l) mem_l[wcnt_l_q[MEM_AW-1:0]] <= cv_gray_l;
    if (we_r) mem_r[wcnt_r_q[MEM_AW-1:0]] <= cv_gray_r;
  end

  always_comb begin
    state_d    = state_q;
    wcnt_l_d   = wcnt_l_q;
    wcnt_r_d   = wcnt_r_q;
    rcnt_d     = rcnt_q;
    phase_d    = phase_q;
    valid_d    = 1'b0;
    row_done_d = 1'b0;
    overflow_d = overflow_q | drop_l | drop_r;
    data_l_d   = data_l_q;
    data_r_d   = data_r_q;
    case (state_q)
      S_FILL: begin
        if (we_l) wcnt_l_d = wcnt_l_q + ADDR_W'(1);
        if (we_r) wcnt_r_d = wcnt_r_q + ADDR_W'(1);
        if ((wcnt_l_q == FULL) && (wcnt_r_q == FULL)) begin
          state_d = S_SEND;
          rcnt_d  = '0;
          phase_d = 1'b0;
        end
      end
      S_SEND: begin
        if (bus.i_valid_l || bus.i_valid_r) overflow_d = 1'b1;
        if (phase_q) begin
          rcnt_d  = rcnt_q + ADDR_W'(1);
          phase_d = 1'b0;
        end else if (rcnt_q == FULL) begin
          // Trailing low cycle of the last pixel closes the row.
          row_done_d = 1'b1;
          wcnt_l_d   = '0;
          wcnt_r_d   = '0;
          rcnt_d     = '0;
          state_d    = S_FILL;
        end else if (bus.i_ready) begin
          valid_d  = 1'b1;
          phase_d  = 1'b1;
          data_l_d = mem_l[rcnt_q[MEM_AW-1:0]];
          data_r_d = mem_r[rcnt_q[MEM_AW-1:0]];
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      wcnt_l_q   <= '0;
      wcnt_r_q   <= '0;
      rcnt_q     <= '0;
      phase_q    <= 1'b0;
      valid_q    <= 1'b0;
      row_done_q <= 1'b0;
      overflow_q <= 1'b0;
      data_l_q   <= '0;
      data_r_q   <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_l_q   <= wcnt_l_d;
      wcnt_r_q   <= wcnt_r_d;
      rcnt_q     <= rcnt_d;
      phase_q    <= phase_d;
      valid_q    <= valid_d;
      row_done_q <= row_done_d;
      overflow_q <= overflow_d;
      data_l_q   <= data_l_d;
      data_r_q   <= data_r_d;
    end
  end

  assign bus.o_valid_l  = valid_q;
  assign bus.o_valid_r  = valid_q;
  assign bus.o_data_l   = data_l_q;
  assign bus.o_data_r   = data_r_q;
  assign bus.o_row_done = row_done_q;
  assign bus.o_overflow = overflow_q;
  assign o_dbg_state    = state_q;

endmodule
